uart_tx: RTL

// - Transmit half of the UART link, the counterpart of the 8N1 receiver.
// - Serialises bytes accepted over a valid/ready handshake onto o_txd.
// - Frame format: start bit, 8 data bits (LSB first), optional parity, 1..2 stop bits.
// - Bit timing comes from an external one-cycle baud strobe i_clk_tx, in the i_clk domain.
// - A one-entry holding buffer allows back-to-back frames with no idle gap.
//

---
 rtl/uart_tx.sv | 103 ++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter with a one-entry holding buffer, optional parity and 1..2 stop bits
module uart_tx #(
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_clk_tx,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_ready,
   output logic       o_txd,
   output logic       o_busy,
   output logic       o_done
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam logic PAR_ODD   = (PARITY_ODD != 0);
   localparam logic LAST_STOP = (STOP_BITS == 2);
   state_t     state;
   logic [7:0] buf_q;
   logic [7:0] shifter;
   logic       buf_full;
   logic [2:0] cnt;
   logic       stop_cnt;
   logic       last;
   logic       load;
   // last: final stop strobe of a frame; load: a buffered byte starts a frame on this strobe
   always_comb begin
      last = (state == STOP) && (stop_cnt == LAST_STOP);
      load = i_clk_tx && buf_full && ((state == IDLE) || last);
   end
   // Handshake, holding buffer and frame sequencer; every output is a register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= IDLE;
         buf_q    <= 8'd0;
         shifter  <= 8'd0;
         buf_full <= 1'b0;
         cnt      <= 3'd0;
         stop_cnt <= 1'b0;
         o_ready  <= 1'b1;
         o_txd    <= 1'b1;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
      end else begin
         o_done <= i_clk_tx && last;
         if (i_valid && o_ready) begin
            buf_q    <= i_data;
            buf_full <= 1'b1;
            o_ready  <= 1'b0;
         end
         if (load) begin
            shifter  <= buf_q;
            buf_full <= 1'b0;
            o_ready  <= 1'b1;
            o_txd    <= 1'b0;
            o_busy   <= 1'b1;
            state    <= START;
         end else if (i_clk_tx) begin
            case (state)
               IDLE: o_txd <= 1'b1;
               START: begin
                  o_txd <= shifter[0];
                  cnt   <= 3'd0;
                  state <= DATA;
               end
               DATA: begin
                  if (cnt != 3'd7) begin
                     cnt   <= cnt + 3'd1;
                     o_txd <= shifter[cnt + 3'd1];
                  end else if (PARITY_EN != 0) begin
                     o_txd <= ^shifter ^ PAR_ODD;
                     state <= PARITY;
                  end else begin
                     o_txd    <= 1'b1;
                     stop_cnt <= 1'b0;
                     state    <= STOP;
                  end
               end
               PARITY: begin
                  o_txd    <= 1'b1;
                  stop_cnt <= 1'b0;
                  state    <= STOP;
               end
               STOP: begin
                  if (last) begin
                     state  <= IDLE;
                     o_busy <= 1'b0;
                  end else begin
                     stop_cnt <= 1'b1;
                  end
               end
               default: begin
                  state  <= IDLE;
                  o_txd  <= 1'b1;
                  o_busy <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule
